// File: rtl/ifu_prefetch_queue.sv
// Instruction fetch unit: fetch PC, redirect select, 1-cycle imem port and a DEPTH-entry prefetch FIFO.
// Define IFU_RANGE_CHECK_EN to also raise AdEL for fetches outside [TEXT_LO, TEXT_HI].
module ifu_prefetch_queue #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_4ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [4:0]  out_exc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (TEXT_LO > TEXT_HI) begin : g_bad_text
        $error("TEXT_LO must not exceed TEXT_HI");
    end

    logic [31:0]   fetch_pc;
    logic          halt;
    logic          inflight;
    logic          inflight_fault;
    logic [31:0]   inflight_pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [4:0]    q_exc   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          fault;
    logic          can_issue;
    logic          push;
    logic          pop;

    assign redirect = exc_req | eret_req | br_req;

    always_comb begin
        redirect_pc = br_target;
        if (exc_req)
            redirect_pc = EXC_VECTOR;
        else if (eret_req)
            redirect_pc = epc;
    end

`ifdef IFU_RANGE_CHECK_EN
    assign fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc < TEXT_LO) || (fetch_pc > TEXT_HI);
`else
    assign fault = (fetch_pc[1:0] != 2'b00);
`endif

    // Slots are reserved at issue time, so an in-flight return always finds room.
    assign can_issue = !reset && !redirect && !halt && ((count + CW'(inflight)) < CW'(DEPTH));
    assign imem_en   = can_issue && !fault;
    assign imem_addr = fetch_pc;

    assign push      = inflight;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? q_instr[rd_ptr] : 32'h0;
    assign out_pc    = out_valid ? q_pc[rd_ptr]    : 32'h0;
    assign out_exc   = out_valid ? q_exc[rd_ptr]   : EXC_NONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            halt           <= 1'b0;
            inflight       <= 1'b0;
            inflight_fault <= 1'b0;
            inflight_pc    <= 32'h0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else if (redirect) begin
            // A pop in this cycle is still taken by decode; everything else is dropped.
            fetch_pc <= redirect_pc;
            halt     <= 1'b0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= can_issue;
            if (can_issue) begin
                inflight_pc    <= fetch_pc;
                inflight_fault <= fault;
                if (fault)
                    halt <= 1'b1;
                else
                    fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                q_instr[wr_ptr] <= inflight_fault ? 32'h0 : imem_rdata;
                q_pc[wr_ptr]    <= inflight_pc;
                q_exc[wr_ptr]   <= inflight_fault ? EXC_ADEL : EXC_NONE;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Directed bench for ifu_prefetch_queue: streaming, backpressure, redirects, faults, reset.
module tb_ifu_prefetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        br_req;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [4:0]  out_exc;

    int checks   = 0;
    int failures = 0;

    ifu_prefetch_queue dut (
        .clk        (clk),
        .reset      (reset),
        .br_req     (br_req),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_exc    (out_exc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h8c5a_0000;
    endfunction

    // Instruction memory: data appears the cycle after the request.
    always @(posedge clk) begin
        if (imem_en)
            imem_rdata <= instr_of(imem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_fetch;
        logic [31:0] exp_pop;
        logic [31:0] head;
        int          first_valid;
        int          n_pops;

        reset = 1'b1; br_req = 1'b0; br_target = 32'h0; exc_req = 1'b0;
        eret_req = 1'b0; epc = 32'h0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_exc", 32'(out_exc), 32'd0);

        // Streaming with decode always ready
        reset = 1'b0;
        #1;
        chk("first_imem_en", 32'(imem_en), 32'd1);
        chk("first_addr", imem_addr, 32'h3000);
        exp_fetch = 32'h3000; exp_pop = 32'h3000; first_valid = -1; n_pops = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid === 1'b1 && first_valid < 0) first_valid = i;
            if (imem_en === 1'b1) begin
                chk("stream_fetch", imem_addr, exp_fetch);
                exp_fetch += 32'd4;
            end
            if (out_valid === 1'b1) begin
                chk("stream_pc", out_pc, exp_pop);
                chk("stream_instr", out_instr, instr_of(exp_pop));
                chk("stream_exc", 32'(out_exc), 32'd0);
                exp_pop += 32'd4;
                n_pops++;
            end
            tick();
        end
        chk("first_valid_cycle", 32'(first_valid), 32'd2);
        chk("stream_made_progress", 32'(n_pops > 3), 32'd1);

        // Backpressure: exactly two entries buffered, fetch stalls
        out_ready = 1'b0;
        repeat (6) tick();
        head = exp_pop;
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_imem_en", 32'(imem_en), 32'd0);
        chk("full_head", out_pc, head);
        out_ready = 1'b1;
        #1;
        tick();
        chk("drain_second", out_pc, head + 32'd4);
        chk("drain_second_valid", 32'(out_valid), 32'd1);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_refetch_en", 32'(imem_en), 32'd1);
        chk("drain_refetch_addr", imem_addr, head + 32'd12);
        tick();
        chk("drain_next_pc", out_pc, head + 32'd8);

        // Branch redirect with queue occupied
        out_ready = 1'b0; br_req = 1'b1; br_target = 32'h3100;
        #1;
        chk("br_cycle_en", 32'(imem_en), 32'd0);
        tick();
        br_req = 1'b0;
        #1;
        chk("br_flushed", 32'(out_valid), 32'd0);
        chk("br_en", 32'(imem_en), 32'd1);
        chk("br_addr", imem_addr, 32'h3100);
        tick();
        chk("br_still_empty", 32'(out_valid), 32'd0);
        tick();
        chk("br_valid", 32'(out_valid), 32'd1);
        chk("br_pc", out_pc, 32'h3100);
        chk("br_instr", out_instr, instr_of(32'h3100));

        // Exception beats branch in the same cycle
        exc_req = 1'b1; br_req = 1'b1; br_target = 32'h3200;
        #1;
        chk("exc_cycle_en", 32'(imem_en), 32'd0);
        tick();
        exc_req = 1'b0; br_req = 1'b0; out_ready = 1'b1;
        #1;
        chk("exc_en", 32'(imem_en), 32'd1);
        exp_fetch = 32'h4180; exp_pop = 32'h4180;
        for (int i = 0; i < 10; i++) begin
            if (imem_en === 1'b1) begin
                chk("exc_fetch", imem_addr, exp_fetch);
                exp_fetch += 32'd4;
            end
            if (out_valid === 1'b1) begin
                chk("exc_pop_pc", out_pc, exp_pop);
                exp_pop += 32'd4;
            end
            tick();
        end

        // ERET to a misaligned address raises AdEL and halts fetch
        out_ready = 1'b0; eret_req = 1'b1; epc = 32'h3006;
        #1;
        chk("eret_cycle_en", 32'(imem_en), 32'd0);
        tick();
        eret_req = 1'b0;
        #1;
        chk("eret_fault_en", 32'(imem_en), 32'd0);
        chk("eret_flushed", 32'(out_valid), 32'd0);
        tick();
        chk("eret_pending", 32'(out_valid), 32'd0);
        tick();
        chk("fault_valid", 32'(out_valid), 32'd1);
        chk("fault_pc", out_pc, 32'h3006);
        chk("fault_exc", 32'(out_exc), 32'd4);
        chk("fault_instr", out_instr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_en", 32'(imem_en), 32'd0);
            chk("halt_hold_pc", out_pc, 32'h3006);
        end
        out_ready = 1'b1;
        tick();
        chk("halt_popped", 32'(out_valid), 32'd0);
        chk("halt_en_after_pop", 32'(imem_en), 32'd0);

        // Branch past TEXT_HI
        br_req = 1'b1; br_target = 32'h5000;
        #1;
        chk("hi_cycle_en", 32'(imem_en), 32'd0);
        tick();
        br_req = 1'b0;
        #1;
`ifdef IFU_RANGE_CHECK_EN
        chk("hi_en", 32'(imem_en), 32'd0);
`else
        chk("hi_en", 32'(imem_en), 32'd1);
        chk("hi_addr", imem_addr, 32'h5000);
`endif
        tick();
        tick();
        chk("hi_valid", 32'(out_valid), 32'd1);
        chk("hi_pc", out_pc, 32'h5000);
`ifdef IFU_RANGE_CHECK_EN
        chk("hi_exc", 32'(out_exc), 32'd4);
        chk("hi_instr", out_instr, 32'h0);
`else
        chk("hi_exc", 32'(out_exc), 32'd0);
        chk("hi_instr", out_instr, instr_of(32'h5000));
`endif

        // Reset in the middle of traffic
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_en", 32'(imem_en), 32'd0);
        chk("mid_rst_pc", out_pc, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_en", 32'(imem_en), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h3000);
        tick();
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_out_pc", out_pc, 32'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
